// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter MMIO slave among N_REQ byte producers.
// Polls STATUS until tx is idle, grants one requester, writes its byte to SBUF, then waits out a guard interval.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int GUARD_CYCLES = 4,
  parameter int ID_W         = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  output logic [N_REQ-1:0]     o_ack,
  output logic                 o_sel,
  output logic                 o_we,
  output logic                 o_re,
  output logic [1:0]           o_addr,
  output logic [15:0]          o_wdata,
  input  logic [15:0]          i_rdata,
  input  logic                 i_rdy,
  output logic                 o_busy,
  output logic [ID_W-1:0]      o_grant_id
);

  localparam logic [1:0] ADDR_SBUF   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [3:0] GUARD_LOAD  = 4'(GUARD_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    GRANT,
    WRITE,
    GUARD
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [3:0]        guard_cnt;
  logic [7:0]        byte_q;

  logic              found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   rr_next;
  logic [7:0]        win_byte;
  int                idx;

  // First set request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win_id = '0;
    idx = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!found && i_req[idx]) begin
        found = 1'b1;
        win_id = ID_W'(idx);
      end
    end
    win_byte = i_data[8*int'(win_id) +: 8];
    rr_next = (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|i_req) begin
          state_nxt = POLL;
        end
      end
      POLL: begin
        // rx_pending (bit 1) is deliberately ignored; only tx_busy gates the write.
        if (i_rdy && !i_rdata[0]) begin
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        state_nxt = found ? WRITE : IDLE;
      end
      WRITE: begin
        if (i_rdy) begin
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        if (guard_cnt <= 4'd1) begin
          state_nxt = (|i_req) ? POLL : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ack = '0;
    if (state == GRANT && found) begin
      o_ack[win_id] = 1'b1;
    end
  end

  assign o_busy = (state != IDLE);

  // Bus outputs are registered from the next state so they are valid throughout each bus state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      guard_cnt  <= 4'd0;
      byte_q     <= 8'h00;
      o_grant_id <= '0;
      o_sel      <= 1'b0;
      o_we       <= 1'b0;
      o_re       <= 1'b0;
      o_addr     <= 2'b00;
      o_wdata    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == GRANT && found) begin
        byte_q     <= win_byte;
        o_grant_id <= win_id;
        rr_ptr     <= rr_next;
      end
      if (state == WRITE && i_rdy) begin
        guard_cnt <= GUARD_LOAD;
      end else if (state == GUARD && guard_cnt != 4'd0) begin
        guard_cnt <= guard_cnt - 1'b1;
      end
      o_sel   <= (state_nxt == POLL) || (state_nxt == WRITE);
      o_re    <= (state_nxt == POLL);
      o_we    <= (state_nxt == WRITE);
      o_addr  <= (state_nxt == POLL) ? ADDR_STATUS : ADDR_SBUF;
      o_wdata <= (state_nxt == WRITE) ? {8'h00, (state == GRANT) ? win_byte : byte_q} : 16'h0000;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple STATUS/SBUF slave and a protocol monitor.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int G = 4;

  logic            i_clk;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [8*N-1:0]  i_data;
  logic [N-1:0]    o_ack;
  logic            o_sel;
  logic            o_we;
  logic            o_re;
  logic [1:0]      o_addr;
  logic [15:0]     o_wdata;
  logic [15:0]     i_rdata;
  logic            i_rdy;
  logic            o_busy;
  logic [1:0]      o_grant_id;

  logic [15:0]     status_val;
  int              checks;
  int              errors;
  int              viol_cnt;
  logic [7:0]      wr_q[$];
  int              ack_q[$];
  logic            last_tx_busy;

  uart_tx_arbiter #(.N_REQ(N), .GUARD_CYCLES(G), .ID_W(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_data(i_data), .o_ack(o_ack),
    .o_sel(o_sel), .o_we(o_we), .o_re(o_re), .o_addr(o_addr), .o_wdata(o_wdata),
    .i_rdata(i_rdata), .i_rdy(i_rdy), .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  assign i_rdata = status_val;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Records acks and SBUF writes; counts protocol violations for a final check.
  always @(negedge i_clk) begin
    if (i_rst) begin
      last_tx_busy = 1'b1;
    end else begin
      if (o_ack != '0) begin
        if (!$onehot(o_ack)) viol_cnt++;
        for (int k = 0; k < N; k++) if (o_ack[k]) ack_q.push_back(k);
      end
      if (o_re && o_addr == 2'b00) viol_cnt++;
      if (o_sel && o_re && i_rdy) last_tx_busy = i_rdata[0];
      if (o_sel && o_we && i_rdy) begin
        if (last_tx_busy !== 1'b0) viol_cnt++;
        if (o_wdata[15:8] !== 8'h00) viol_cnt++;
        wr_q.push_back(o_wdata[7:0]);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Each requester withdraws in the cycle after its ack.
  task automatic run_requesters(input int n);
    logic [N-1:0] drop;
    drop = o_ack;
    for (int c = 0; c < n; c++) begin
      tick();
      i_req = i_req & ~drop;
      drop = o_ack;
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    i_req = '0;
    tick();
    tick();
    i_rst = 1'b0;
    tick();
    wr_q.delete();
    ack_q.delete();
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_req = '0;
    tick();
    checks++;
    if ({o_sel, o_we, o_re, o_busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: sel/we/re/busy=%b required 0000", {o_sel, o_we, o_re, o_busy});
    end
    checks++;
    if (o_addr !== 2'b00 || o_wdata !== 16'h0000 || o_grant_id !== 2'd0 || o_ack !== 4'b0000) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h gid=%0d ack=%b required all zero", o_addr, o_wdata, o_grant_id, o_ack);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int guard_len;
    do_reset();
    status_val = 16'h0000;
    i_data = {8'h13, 8'hA5, 8'h11, 8'h10};
    i_req = 4'b0100;
    tick();
    checks++;
    if ({o_busy, o_sel, o_re, o_we} !== 4'b1110 || o_addr !== 2'b01) begin
      errors++; $display("FAIL single_poll: busy/sel/re/we=%b addr=%b required 1110 addr 01", {o_busy, o_sel, o_re, o_we}, o_addr);
    end
    tick();
    checks++;
    if (o_ack !== 4'b0100 || o_sel !== 1'b0) begin
      errors++; $display("FAIL single_ack: ack=%b sel=%b required 0100 sel 0", o_ack, o_sel);
    end
    tick();
    i_req = 4'b0000;
    checks++;
    if ({o_sel, o_we, o_re} !== 3'b110 || o_addr !== 2'b00 || o_wdata !== 16'h00A5 || o_ack !== 4'b0000) begin
      errors++; $display("FAIL single_write: sel/we/re=%b addr=%b wdata=%h ack=%b required 110 00 00a5 0000", {o_sel, o_we, o_re}, o_addr, o_wdata, o_ack);
    end
    checks++;
    if (o_grant_id !== 2'd2) begin
      errors++; $display("FAIL single_grant_id: got %0d required 2", o_grant_id);
    end
    guard_len = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_busy && !o_sel) guard_len++;
    end
    checks++;
    if (guard_len !== G) begin
      errors++; $display("FAIL guard_len: got %0d cycles required %0d", guard_len, G);
    end
    checks++;
    if (o_busy !== 1'b0 || ack_q.size() !== 1 || wr_q.size() !== 1) begin
      errors++; $display("FAIL single_done: busy=%b acks=%0d writes=%0d required 0 1 1", o_busy, ack_q.size(), wr_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_b[5];
    int exp_a[5];
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    exp_a = '{0, 1, 2, 3, 0};
    do_reset();
    status_val = 16'h0000;
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_req = 4'b1111;
    for (int c = 0; c < 300 && wr_q.size() < 5; c++) tick();
    i_req = 4'b0000;
    run_requesters(15);
    checks++;
    if (wr_q.size() !== 5 || ack_q.size() !== 5) begin
      errors++; $display("FAIL rr_count: writes=%0d acks=%0d required 5 5", wr_q.size(), ack_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wr_q[i] !== exp_b[i] || ack_q[i] !== exp_a[i]) begin
          errors++; $display("FAIL rr_order[%0d]: byte=%h ack=%0d required %h %0d", i, wr_q[i], ack_q[i], exp_b[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_busy_poll();
    int rd_cnt;
    do_reset();
    status_val = 16'h0001;
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_req = 4'b0001;
    rd_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_sel && o_re && o_addr == 2'b01) rd_cnt++;
    end
    checks++;
    if (rd_cnt !== 20 || ack_q.size() !== 0 || wr_q.size() !== 0) begin
      errors++; $display("FAIL busy_poll: reads=%0d acks=%0d writes=%0d required 20 0 0", rd_cnt, ack_q.size(), wr_q.size());
    end
    status_val = 16'h0000;
    tick();
    checks++;
    if (o_ack !== 4'b0001) begin
      errors++; $display("FAIL busy_release_ack: got %b required 0001", o_ack);
    end
    run_requesters(15);
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== 8'h10) begin
      errors++; $display("FAIL busy_release_write: writes=%0d first=%h required 1 10", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 8'hxx);
    end
  endtask

  task automatic test_rx_pending();
    do_reset();
    status_val = 16'h0002;
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_req = 4'b0010;
    run_requesters(15);
    checks++;
    if (ack_q.size() !== 1 || ack_q[0] !== 1 || wr_q.size() !== 1 || wr_q[0] !== 8'h11) begin
      errors++; $display("FAIL rx_pending: acks=%0d writes=%0d required one ack of 1 and write 11", ack_q.size(), wr_q.size());
    end
    status_val = 16'h0000;
  endtask

  task automatic test_withdraw();
    do_reset();
    status_val = 16'h0000;
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_req = 4'b0010;
    tick();
    i_req = 4'b0000;
    tick();
    checks++;
    if (o_ack !== 4'b0000 || o_busy !== 1'b1 || o_sel !== 1'b0) begin
      errors++; $display("FAIL withdraw_grant: ack=%b busy=%b sel=%b required 0000 1 0", o_ack, o_busy, o_sel);
    end
    tick();
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL withdraw_idle: busy=%b required 0", o_busy);
    end
    i_req = 4'b1111;
    run_requesters(40);
    checks++;
    if (ack_q.size() !== 4 || ack_q[0] !== 0 || ack_q[3] !== 3) begin
      errors++; $display("FAIL withdraw_rr_kept: acks=%0d first=%0d required 4 acks starting at 0", ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    status_val = 16'h0000;
    i_rdy = 1'b1;
    i_data = {8'h13, 8'h12, 8'h11, 8'h10};
    i_req = 4'b1000;
    tick();
    tick();
    checks++;
    if (o_ack !== 4'b1000) begin
      errors++; $display("FAIL rst_pre_ack: got %b required 1000", o_ack);
    end
    i_rdy = 1'b0;
    tick();
    checks++;
    if ({o_sel, o_we} !== 2'b11 || o_wdata !== 16'h0013) begin
      errors++; $display("FAIL rst_pre_write: sel/we=%b wdata=%h required 11 0013", {o_sel, o_we}, o_wdata);
    end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_sel, o_we, o_busy} !== 3'b000 || o_wdata !== 16'h0000 || o_ack !== 4'b0000) begin
      errors++; $display("FAIL rst_async_drop: sel/we/busy=%b wdata=%h ack=%b required 000 0000 0000", {o_sel, o_we, o_busy}, o_wdata, o_ack);
    end
    tick();
    tick();
    i_rst = 1'b0;
    i_rdy = 1'b1;
    wr_q.delete();
    ack_q.delete();
    run_requesters(15);
    checks++;
    if (ack_q.size() !== 1 || ack_q[0] !== 3 || o_grant_id !== 2'd3 || wr_q.size() !== 1 || wr_q[0] !== 8'h13) begin
      errors++; $display("FAIL rst_regrant: acks=%0d gid=%0d writes=%0d required one ack of 3, gid 3, write 13", ack_q.size(), o_grant_id, wr_q.size());
    end
    ack_q.delete();
    i_req = 4'b0110;
    run_requesters(30);
    checks++;
    if (ack_q.size() !== 2 || ack_q[0] !== 1 || ack_q[1] !== 2) begin
      errors++; $display("FAIL rst_rr_wrap: acks=%0d first=%0d required 2 acks 1 then 2", ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol_cnt !== 0) begin
      errors++; $display("FAIL protocol: %0d violations (multi-ack, read of SBUF, write after busy status or nonzero upper wdata) required 0", viol_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    viol_cnt = 0;
    last_tx_busy = 1'b1;
    i_rst = 1'b1;
    i_req = '0;
    i_data = '0;
    i_rdy = 1'b1;
    status_val = 16'h0000;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_poll();
    test_rx_pending();
    test_withdraw();
    test_reset_mid_write();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
